// File: rtl/aes_inv_subbytes_ctrl.sv
// rtl/aes_inv_subbytes_ctrl.sv - Time-multiplexed InvSubBytes over a 128-bit AES state; optional lookup pipeline via AES_INVSUB_PIPE_EN
module aes_inv_subbytes_ctrl #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);
  localparam int N  = 16 / LANES;
  localparam int GW = 8 * LANES;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  generate
    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
      $error("aes_inv_subbytes_ctrl: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // Inverse S-box, entry 0 first
  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
`ifdef AES_INVSUB_PIPE_EN
    S_DRAIN = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [CW-1:0]   cnt;
  logic [127:0]    work;
  logic [127:0]    work_nxt;
  logic [GW-1:0]   grp_in;
  logic [GW-1:0]   grp_sub;
  logic            wb_en;
  logic [CW-1:0]   wb_idx;
  logic [GW-1:0]   wb_data;

  // Pick the active group from the working register and run each byte through its lane lookup
  always_comb begin
    grp_sub = '0;
    grp_in  = work[127 - int'(cnt) * GW -: GW];
    for (int j = 0; j < LANES; j++) begin
      grp_sub[GW-1-8*j -: 8] = INV_SBOX[grp_in[GW-1-8*j -: 8]];
    end
  end

`ifdef AES_INVSUB_PIPE_EN
  logic [GW-1:0] pipe_data;
  logic [CW-1:0] pipe_idx;

  // Hold lookup results with their group index for one cycle before write-back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_data <= '0;
      pipe_idx  <= '0;
    end else if (state == S_RUN) begin
      pipe_data <= grp_sub;
      pipe_idx  <= cnt;
    end
  end

  // The first RUN cycle has nothing registered yet; DRAIN flushes the last group
  assign wb_en   = (state == S_RUN && cnt != '0) || (state == S_DRAIN);
  assign wb_idx  = pipe_idx;
  assign wb_data = pipe_data;
`else
  assign wb_en   = (state == S_RUN);
  assign wb_idx  = cnt;
  assign wb_data = grp_sub;
`endif

  // Working register next value: load on accept, otherwise patch one group in place
  always_comb begin
    work_nxt = work;
    if (state == S_IDLE && in_valid) begin
      work_nxt = state_in;
    end else if (wb_en) begin
      work_nxt[127 - int'(wb_idx) * GW -: GW] = wb_data;
    end
  end

  // Working register and group counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work <= '0;
      cnt  <= '0;
    end else begin
      work <= work_nxt;
      if (state == S_IDLE && in_valid) begin
        cnt <= '0;
      end else if (state == S_RUN) begin
        cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (in_valid) state_nxt = S_RUN;
`ifdef AES_INVSUB_PIPE_EN
      S_RUN:   if (cnt == CNT_LAST) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
`else
      S_RUN:  if (cnt == CNT_LAST) state_nxt = S_DONE;
`endif
      S_DONE: if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; in_ready stays low while reset is held
  always_comb begin
    in_ready  = rst_n && (state == S_IDLE);
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
  end

  assign state_out = work;

endmodule

// File: tb/tb_aes_inv_subbytes_ctrl.sv
// tb/tb_aes_inv_subbytes_ctrl.sv - Self-checking bench for aes_inv_subbytes_ctrl
module tb_aes_inv_subbytes_ctrl;
  localparam int P_LANES = 4;
  localparam int N = 16 / P_LANES;
`ifdef AES_INVSUB_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif
  localparam logic [127:0] BYTE_IN  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] BYTE_OUT = 128'h52096ad53036a538bf40a39e81f3d7fb;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;
  logic         busy;

  logic         sw_valid;
  logic [127:0] sw_state;
  logic         sw_out_ready;
  logic         l1_in_ready, l1_out_valid, l1_busy;
  logic [127:0] l1_state_out;
  logic         l16_in_ready, l16_out_valid, l16_busy;
  logic [127:0] l16_state_out;

  int checks;
  int failures;
  logic [7:0]   inv_tab [256];
  logic [127:0] exp_q [$];

  typedef struct {
    logic [127:0] din;
    logic [127:0] dexp;
  } vec_t;
  vec_t vecs [6];

  aes_inv_subbytes_ctrl #(.LANES(P_LANES)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .state_in(state_in), .out_valid(out_valid), .out_ready(out_ready),
    .state_out(state_out), .busy(busy)
  );

  aes_inv_subbytes_ctrl #(.LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(l1_in_ready),
    .state_in(sw_state), .out_valid(l1_out_valid), .out_ready(sw_out_ready),
    .state_out(l1_state_out), .busy(l1_busy)
  );

  aes_inv_subbytes_ctrl #(.LANES(16)) u_l16 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(l16_in_ready),
    .state_in(sw_state), .out_valid(l16_out_valid), .out_ready(sw_out_ready),
    .state_out(l16_state_out), .busy(l16_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] y);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8];
    return r ^ 8'h05;
  endfunction

  function automatic logic [127:0] ref_state(input logic [127:0] s);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = inv_tab[s[127-8*k -: 8]];
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Called at a negedge; returns at the negedge following the accept edge
  task automatic send(input logic [127:0] s, input logic [127:0] e, output time t_acc);
    int n;
    n = 0;
    exp_q.push_back(e);
    state_in = s;
    in_valid = 1'b1;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_wait", 128'(in_ready), 128'd1);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    in_valid = 1'b0;
    state_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Polls at negedges for out_valid, then scores data and latency
  task automatic receive(input string name, input time t_acc, input int lat_exp);
    int n;
    logic [127:0] e;
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, 128'(out_valid), 128'd1);
    if (out_valid) begin
      e = '0;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      chk({name, "_data"}, state_out, e);
      chk({name, "_lat"}, 128'(($time - t_acc - 5) / 10), 128'(lat_exp));
    end
  endtask

  initial begin
    time t1;
    time t2;
    logic [127:0] snap;
    logic [127:0] d1;
    logic [127:0] d16;
    int lat1;
    int lat16;
    logic [7:0] a;

    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    state_in = '0;
    sw_valid = 1'b0;
    sw_state = '0;
    sw_out_ready = 1'b1;

    for (int y = 0; y < 256; y++) begin
      a = inv_affine(8'(y));
      inv_tab[y] = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(a, 8'(x)) == 8'h01) inv_tab[y] = 8'(x);
      end
    end

    vecs[0].din = {16{8'h63}};  vecs[0].dexp = '0;
    vecs[1].din = BYTE_IN;      vecs[1].dexp = BYTE_OUT;
    vecs[2].din = {16{8'hff}};  vecs[2].dexp = {16{8'h7d}};
    for (int i = 3; i < 6; i++) begin
      vecs[i].din  = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].dexp = ref_state(vecs[i].din);
    end

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd0);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(in_ready), 128'd1);

    // Table-driven vectors
    for (int i = 0; i < 6; i++) begin
      send(vecs[i].din, vecs[i].dexp, t1);
      receive($sformatf("vec%0d", i), t1, N + PIPE);
      @(negedge clk);
    end

    // Back-pressure in DONE with an ignored in_valid pulse
    out_ready = 1'b0;
    send(BYTE_IN, BYTE_OUT, t1);
    receive("bp", t1, N + PIPE);
    snap = state_out;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        state_in = {16{8'h63}};
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      chk("bp_state_out", state_out, snap);
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_out_valid", 128'(out_valid), 128'd0);
    chk("bp_release_busy", 128'(busy), 128'd0);
    chk("bp_release_state_out", state_out, BYTE_OUT);

    // Back-to-back issue
    send({16{8'hff}}, {16{8'h7d}}, t1);
    receive("b2b_first", t1, N + PIPE);
    send(BYTE_IN, BYTE_OUT, t2);
    receive("b2b_second", t2, N + PIPE);
    chk("b2b_interval", 128'((t2 - t1) / 10), 128'(N + 2 + PIPE));
    @(negedge clk);

    // Reset while RUN at cnt=2
    send({16{8'h63}}, '0, t1);
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", 128'(busy), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_state_out", state_out, 128'd0);
    chk("mid_rst_in_ready", 128'(in_ready), 128'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send({16{8'h63}}, '0, t1);
    receive("after_rst", t1, N + PIPE);
    @(negedge clk);

    // LANES sweep
    chk("sw_l1_in_ready", 128'(l1_in_ready), 128'd1);
    chk("sw_l16_busy", 128'(l16_busy), 128'd0);
    sw_state = BYTE_IN;
    sw_valid = 1'b1;
    @(posedge clk);
    t1 = $time;
    @(negedge clk);
    sw_valid = 1'b0;
    sw_state = '0;
    lat1 = -1;
    lat16 = -1;
    d1 = '0;
    d16 = '0;
    for (int i = 0; i < 40; i++) begin
      if (l1_out_valid && lat1 < 0) begin
        lat1 = int'(($time - t1 - 5) / 10);
        d1 = l1_state_out;
      end
      if (l16_out_valid && lat16 < 0) begin
        lat16 = int'(($time - t1 - 5) / 10);
        d16 = l16_state_out;
      end
      @(negedge clk);
    end
    chk("sw_l1_data", d1, BYTE_OUT);
    chk("sw_l1_lat", 128'(lat1), 128'(16 + PIPE));
    chk("sw_l16_data", d16, BYTE_OUT);
    chk("sw_l16_lat", 128'(lat16), 128'(1 + PIPE));
    chk("sw_l1_busy_end", 128'(l1_busy), 128'd0);
    chk("sw_l16_in_ready_end", 128'(l16_in_ready), 128'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_inv_subbytes_ctrl.md
# aes_inv_subbytes_ctrl

Sequencer that applies the FIPS-197 InvSubBytes transform to a full 128-bit AES state using a reduced number of inverse S-box lookup instances, time-multiplexed over several cycles. It sits in the decryption round datapath between InvShiftRows and AddRoundKey. It trades lookup-table area for latency, is controlled by valid/ready handshakes on both sides, and instantiates `aes_inv_sbox`-equivalent lookups internally: LANES instances, each 8-bit in, 8-bit out, purely combinational.

## Interface
- `LANES`, default 4: bytes substituted per cycle. Legal values are 1, 2, 4, 8, 16; any other value fails elaboration. Defines N = 16/LANES.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_valid`  in  1  `state_in` is valid.
- `in_ready`  out  1  block can accept a state.
- `state_in`  in  128  input state. Byte k = `state_in[127-8k -: 8]`, so byte 0 is the MSB (FIPS order).
- `out_valid`  out  1  `state_out` holds a completed result.
- `out_ready`  in  1  downstream accepts the result.
- `state_out`  out  128  working or result register, same byte order as `state_in`.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- **FSM states:** IDLE, RUN, DRAIN (DRAIN exists only with the macro), DONE.
- **IDLE:**
  - `in_ready`=1.
  - On `in_valid`&&`in_ready`, load `state_in` into the working register, clear group counter `cnt`, and go to RUN.
- **RUN:**
  - Each cycle, group `cnt` (bytes cnt·LANES … cnt·LANES+LANES−1) passes through the LANES lookups.
  - Results are written back in place; all other bytes are unchanged.
  - `cnt` increments by 1 each cycle.
  - When `cnt` = N−1: go to DONE (without macro) or to DRAIN (with macro). `cnt` then wraps to 0.
- **DRAIN:**
  - Writes the last registered group.
  - Goes to DONE.
- **DONE:**
  - `out_valid`=1 and `state_out` is stable.
  - On `out_ready`, go to IDLE.
  - `in_valid` is ignored until IDLE; `in_ready`=0 in DONE.
- **Flow rules:**
  - `in_ready`=1 only in IDLE.
  - No new state is accepted while RUN, DRAIN or DONE is in progress.
  - `state_in` is sampled only on the accept edge; later changes to it have no effect.
- **`state_out`:** always drives the working register. Its value is meaningful only while `out_valid`=1.
- **Reset:**
  - `rst_n` low at any time, including mid-RUN, forces IDLE asynchronously.
  - Values in reset: `cnt`=0, working register = 0, `out_valid`=0, `busy`=0, `in_ready`=0.
  - After `rst_n` rises, `in_ready`=1 in IDLE.
  - Any partial result is discarded.

## Timing
- **Accept edge:** E0. The RUN group writes happen at edges E1…EN.
- **Latency without macro:**
  - `out_valid` rises after edge EN, i.e. N cycles after accept (4 for LANES=4, 1 for LANES=16).
  - The DONE→IDLE handshake takes 1 cycle.
  - Minimum issue interval is N+2 cycles.
- **Latency with macro:** N+1 cycles; minimum issue interval is N+3 cycles.
- **Back-pressure:** `out_valid` held with `out_ready`=0 keeps `state_out` bit-stable for any number of cycles.
- **Lookups:** combinational from the working register. There is no combinational path from `in_valid` to `in_ready`, or from `out_ready` to `out_valid`.

## Configuration
- **`AES_INVSUB_PIPE_EN` defined:**
  - The LANES lookup outputs, together with their group index, are registered one cycle before write-back.
  - The DRAIN state is present and latency is N+1.
  - This shortens the critical path.
- **`AES_INVSUB_PIPE_EN` undefined:**
  - Lookup results are written back in the same cycle.
  - The DRAIN state is absent and latency is N.

## Test plan
- **All-0x63 state:** `state_in`=128'h6363…63 (LANES=4) -> `state_out`=128'h0 with `out_valid` exactly 4 cycles after accept (5 with macro).
- **Byte-order check:** `state_in`=128'h000102030405060708090a0b0c0d0e0f -> `state_out`=128'h52096ad53036a538bf40a39e81f3d7fb.
- **Back-pressure:** hold `out_ready`=0 for 10 cycles in DONE -> `state_out` and `out_valid` stay stable; `in_ready`=0 throughout; a pulse on `in_valid` is ignored.
- **Back-to-back issue:** issue two states back-to-back with `out_ready`=1, first 128'hff…ff then the byte-order vector -> results 128'h7d…7d then the byte-order result; second accept occurs exactly N+2 cycles after the first (N+3 with macro).
- **Reset mid-operation:** assert `rst_n`=0 during RUN at cnt=2 -> `out_valid`=0, `busy`=0 and `state_out`=0 immediately; after release, a fresh 128'h6363…63 yields 128'h0 normally.
- **LANES sweep:** LANES=1 and LANES=16 with the byte-order vector -> same result, latency 16 and 1 cycles respectively (without macro).
